// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order window of ROB_SIZE entries addressed by tags 1..ROB_SIZE.
// Captures results from the ALU and LS CDBs, retires one ready head entry per cycle and
// flushes everything with a PC redirect when a committing branch was mispredicted.
module reorder_buffer #(
   parameter int unsigned ROB_SIZE = 15,
   parameter int unsigned TAG_W    = 4,
   parameter int unsigned DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              alloc_ena,
   input  logic              alloc_has_rd,
   input  logic [4:0]        alloc_rd,
   input  logic              alloc_is_store,
   input  logic              alloc_is_branch,
   input  logic [DATA_W-1:0] alloc_pred_next_pc,
   output logic [TAG_W-1:0]  alloc_tag,
   output logic              has_capacity,
   input  logic [TAG_W-1:0]  in_alu_cdb_rob_tag,
   input  logic [DATA_W-1:0] in_alu_cdb_data,
   input  logic [DATA_W-1:0] in_alu_cdb_next_pc,
   input  logic [TAG_W-1:0]  in_ls_cdb_rob_tag,
   input  logic [DATA_W-1:0] in_ls_cdb_data,
   input  logic [TAG_W-1:0]  query_tag_a,
   input  logic [TAG_W-1:0]  query_tag_b,
   output logic              query_ready_a,
   output logic              query_ready_b,
   output logic [DATA_W-1:0] query_data_a,
   output logic [DATA_W-1:0] query_data_b,
   output logic              commit_rf_ena,
   output logic [4:0]        commit_rd,
   output logic [DATA_W-1:0] commit_data,
   output logic [TAG_W-1:0]  commit_tag,
   output logic              commit_store_ena,
   output logic              flush,
   output logic [DATA_W-1:0] redirect_pc
);

   // Storage covers every encodable tag; slot 0 and slots above ROB_SIZE are never busy.
   localparam int unsigned      NumSlots = 2 ** TAG_W;
   localparam logic [TAG_W-1:0] LastTag  = TAG_W'(ROB_SIZE);
   localparam logic [TAG_W-1:0] FirstTag = TAG_W'(1);

   logic [NumSlots-1:0] busy_q, ready_q;
   logic [NumSlots-1:0] has_rd_q, is_store_q, is_branch_q;
   logic [4:0]          rd_q         [NumSlots];
   logic [DATA_W-1:0]   value_q      [NumSlots];
   logic [DATA_W-1:0]   pred_npc_q   [NumSlots];
   logic [DATA_W-1:0]   actual_npc_q [NumSlots];

   logic [TAG_W-1:0]    head_q, tail_q, count_q, count_d;
   logic [NumSlots-1:0] cap_ls, cap_alu;
   logic                do_commit, do_alloc, mispredict;

   logic [TAG_W-1:0]    q_tag [2];
   logic                q_rdy [2];
   logic [DATA_W-1:0]   q_dat [2];

   function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] p);
      return (p == LastTag) ? FirstTag : p + FirstTag;
   endfunction

   // Per-entry CDB match; LS wins when both buses carry the same tag.
   always_comb begin
      for (int i = 0; i < NumSlots; i++) begin
         cap_ls[i]  = ena && busy_q[i] && (in_ls_cdb_rob_tag != '0) &&
                      (in_ls_cdb_rob_tag == TAG_W'(i));
         cap_alu[i] = ena && busy_q[i] && (in_alu_cdb_rob_tag != '0) &&
                      (in_alu_cdb_rob_tag == TAG_W'(i)) && !cap_ls[i];
      end
   end

   // Commit/alloc decisions from registered state; a mispredict kills same-cycle alloc.
   always_comb begin
      has_capacity = count_q < LastTag;
      alloc_tag    = tail_q;
      do_commit    = ena && busy_q[head_q] && ready_q[head_q];
      mispredict   = do_commit && is_branch_q[head_q] &&
                     (actual_npc_q[head_q] != pred_npc_q[head_q]);
      do_alloc     = ena && alloc_ena && has_capacity && !mispredict;
      count_d      = count_q;
      if (do_alloc && !do_commit) begin
         count_d = count_q + FirstTag;
      end else if (do_commit && !do_alloc) begin
         count_d = count_q - FirstTag;
      end
   end

   // Entry occupancy and circular pointers.
   always_ff @(posedge clk) begin
      if (rst || mispredict) begin
         busy_q  <= '0;
         ready_q <= '0;
         head_q  <= FirstTag;
         tail_q  <= FirstTag;
         count_q <= '0;
      end else begin
         ready_q <= ready_q | cap_ls | cap_alu;
         if (do_commit) begin
            busy_q[head_q]  <= 1'b0;
            ready_q[head_q] <= 1'b0;
            head_q          <= next_ptr(head_q);
         end
         if (do_alloc) begin
            busy_q[tail_q]  <= 1'b1;
            ready_q[tail_q] <= 1'b0;
            tail_q          <= next_ptr(tail_q);
         end
         count_q <= count_d;
      end
   end

   // Entry payload: decoder fields on alloc, results on CDB capture.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NumSlots; i++) begin
         if (cap_ls[i]) begin
            value_q[i] <= in_ls_cdb_data;
         end else if (cap_alu[i]) begin
            value_q[i]      <= in_alu_cdb_data;
            actual_npc_q[i] <= in_alu_cdb_next_pc;
         end
      end
      if (do_alloc) begin
         has_rd_q[tail_q]    <= alloc_has_rd;
         rd_q[tail_q]        <= alloc_rd;
         is_store_q[tail_q]  <= alloc_is_store;
         is_branch_q[tail_q] <= alloc_is_branch;
         pred_npc_q[tail_q]  <= alloc_pred_next_pc;
      end
   end

   // Registered retirement and redirect outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         commit_rf_ena    <= 1'b0;
         commit_store_ena <= 1'b0;
         commit_rd        <= '0;
         commit_data      <= '0;
         commit_tag       <= '0;
         flush            <= 1'b0;
         redirect_pc      <= '0;
      end else begin
         commit_rf_ena    <= do_commit && has_rd_q[head_q] && (rd_q[head_q] != 5'd0);
         commit_store_ena <= do_commit && is_store_q[head_q];
         flush            <= mispredict;
         if (do_commit) begin
            commit_tag  <= head_q;
            commit_rd   <= rd_q[head_q];
            commit_data <= value_q[head_q];
         end
         if (mispredict) begin
            redirect_pc <= actual_npc_q[head_q];
         end
      end
   end

   assign q_tag[0] = query_tag_a;
   assign q_tag[1] = query_tag_b;

   // Operand lookup with same-cycle CDB bypass; tag 0 means "no producer".
   always_comb begin
      for (int q = 0; q < 2; q++) begin
         q_rdy[q] = 1'b0;
         q_dat[q] = '0;
         if (q_tag[q] == '0) begin
            q_rdy[q] = 1'b1;
         end else if (busy_q[q_tag[q]]) begin
            if (cap_ls[q_tag[q]]) begin
               q_rdy[q] = 1'b1;
               q_dat[q] = in_ls_cdb_data;
            end else if (cap_alu[q_tag[q]]) begin
               q_rdy[q] = 1'b1;
               q_dat[q] = in_alu_cdb_data;
            end else begin
               q_rdy[q] = ready_q[q_tag[q]];
               q_dat[q] = value_q[q_tag[q]];
            end
         end
      end
   end

   assign query_ready_a = q_rdy[0];
   assign query_ready_b = q_rdy[1];
   assign query_data_a  = q_dat[0];
   assign query_data_b  = q_dat[1];

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: table-driven allocation vectors, directed multi-cycle sequences,
// and a commit scoreboard filled at allocation time and drained by a negedge monitor.
module tb_reorder_buffer;

   localparam int TAG_W  = 4;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst, ena;
   logic              alloc_ena, alloc_has_rd, alloc_is_store, alloc_is_branch;
   logic [4:0]        alloc_rd;
   logic [DATA_W-1:0] alloc_pred_next_pc;
   logic [TAG_W-1:0]  alloc_tag;
   logic              has_capacity;
   logic [TAG_W-1:0]  in_alu_cdb_rob_tag, in_ls_cdb_rob_tag;
   logic [DATA_W-1:0] in_alu_cdb_data, in_alu_cdb_next_pc, in_ls_cdb_data;
   logic [TAG_W-1:0]  query_tag_a, query_tag_b;
   logic              query_ready_a, query_ready_b;
   logic [DATA_W-1:0] query_data_a, query_data_b;
   logic              commit_rf_ena, commit_store_ena, flush;
   logic [4:0]        commit_rd;
   logic [DATA_W-1:0] commit_data, redirect_pc;
   logic [TAG_W-1:0]  commit_tag;

   reorder_buffer #(.ROB_SIZE(15), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk                (clk),
      .rst                (rst),
      .ena                (ena),
      .alloc_ena          (alloc_ena),
      .alloc_has_rd       (alloc_has_rd),
      .alloc_rd           (alloc_rd),
      .alloc_is_store     (alloc_is_store),
      .alloc_is_branch    (alloc_is_branch),
      .alloc_pred_next_pc (alloc_pred_next_pc),
      .alloc_tag          (alloc_tag),
      .has_capacity       (has_capacity),
      .in_alu_cdb_rob_tag (in_alu_cdb_rob_tag),
      .in_alu_cdb_data    (in_alu_cdb_data),
      .in_alu_cdb_next_pc (in_alu_cdb_next_pc),
      .in_ls_cdb_rob_tag  (in_ls_cdb_rob_tag),
      .in_ls_cdb_data     (in_ls_cdb_data),
      .query_tag_a        (query_tag_a),
      .query_tag_b        (query_tag_b),
      .query_ready_a      (query_ready_a),
      .query_ready_b      (query_ready_b),
      .query_data_a       (query_data_a),
      .query_data_b       (query_data_b),
      .commit_rf_ena      (commit_rf_ena),
      .commit_rd          (commit_rd),
      .commit_data        (commit_data),
      .commit_tag         (commit_tag),
      .commit_store_ena   (commit_store_ena),
      .flush              (flush),
      .redirect_pc        (redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic              rf;
      logic [4:0]        rd;
      logic [DATA_W-1:0] data;
      logic              st;
   } exp_t;

   typedef struct {
      logic              has_rd;
      logic [4:0]        rd;
      logic              is_store;
      logic [DATA_W-1:0] data;
      logic              exp_rf;
      logic              exp_st;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Every visible commit pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (commit_rf_ena === 1'b1 || commit_store_ena === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_commit: actual tag=%0d rf=%0b st=%0b required no commit",
                     commit_tag, commit_rf_ena, commit_store_ena);
         end else begin
            e = sb.pop_front();
            check("commit_tag", commit_tag, e.tag);
            check("commit_rf_ena", commit_rf_ena, e.rf);
            check("commit_store_ena", commit_store_ena, e.st);
            if (e.rf) begin
               check("commit_rd", commit_rd, e.rd);
               check("commit_data", commit_data, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cdb();
      in_alu_cdb_rob_tag = '0;
      in_alu_cdb_data    = '0;
      in_alu_cdb_next_pc = '0;
      in_ls_cdb_rob_tag  = '0;
      in_ls_cdb_data     = '0;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      ena          = 1'b1;
      alloc_ena    = 1'b0;
      alloc_has_rd = 1'b0;
      alloc_rd     = '0;
      alloc_is_store     = 1'b0;
      alloc_is_branch    = 1'b0;
      alloc_pred_next_pc = '0;
      query_tag_a  = '0;
      query_tag_b  = '0;
      idle_cdb();
      tick();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic do_alloc(input logic hr, input logic [4:0] rd, input logic st, input logic br,
                           input logic [DATA_W-1:0] pred, input logic [TAG_W-1:0] exp_tag);
      check("alloc_tag", alloc_tag, exp_tag);
      alloc_ena          = 1'b1;
      alloc_has_rd       = hr;
      alloc_rd           = rd;
      alloc_is_store     = st;
      alloc_is_branch    = br;
      alloc_pred_next_pc = pred;
      tick();
      alloc_ena = 1'b0;
   endtask

   task automatic alu(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data,
                      input logic [DATA_W-1:0] npc);
      in_alu_cdb_rob_tag = tag;
      in_alu_cdb_data    = data;
      in_alu_cdb_next_pc = npc;
      tick();
      idle_cdb();
   endtask

   task automatic ls(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
      in_ls_cdb_rob_tag = tag;
      in_ls_cdb_data    = data;
      tick();
      idle_cdb();
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
      check("drain_outstanding", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_alloc_tag", alloc_tag, 1);
      check("rst_has_capacity", has_capacity, 1);
      check("rst_rf_ena", commit_rf_ena, 0);
      check("rst_store_ena", commit_store_ena, 0);
      check("rst_flush", flush, 0);
      check("rst_commit_tag", commit_tag, 0);
      check("rst_redirect", redirect_pc, 0);

      // Table-driven allocation: ALU ops, a store, rd=0 writer, no-rd op
      vecs[0] = '{1'b1, 5'd5, 1'b0, 32'h55, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 5'd6, 1'b0, 32'h66, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 5'd7, 1'b0, 32'h77, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 5'd0, 1'b1, 32'hA0, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 5'd0, 1'b0, 32'h99, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 5'd3, 1'b0, 32'h33, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         do_alloc(vecs[i].has_rd, vecs[i].rd, vecs[i].is_store, 1'b0, '0, TAG_W'(i + 1));
         if (vecs[i].exp_rf || vecs[i].exp_st)
            sb.push_back('{TAG_W'(i + 1), vecs[i].exp_rf, vecs[i].rd, vecs[i].data,
                           vecs[i].exp_st});
      end
      // Out-of-order completion, in-order retirement with exact latency
      alu(2, 32'h66, '0);
      check("no_commit_head_busy", commit_rf_ena, 0);
      alu(1, 32'h55, '0);
      check("no_early_commit", commit_rf_ena, 0);
      tick();
      check("commit1_rf", commit_rf_ena, 1);
      check("commit1_tag", commit_tag, 1);
      tick();
      check("commit2_rf", commit_rf_ena, 1);
      check("commit2_tag", commit_tag, 2);
      for (int i = 2; i < 6; i++) begin
         if (vecs[i].is_store) ls(TAG_W'(i + 1), vecs[i].data);
         else alu(TAG_W'(i + 1), vecs[i].data, '0);
      end
      drain();
      query_tag_a = 5;
      #1;
      check("query_retired_ready", query_ready_a, 0);
      // Head must have moved past the silent commits
      do_alloc(1'b1, 5'd10, 1'b0, 1'b0, '0, 7);
      sb.push_back('{4'd7, 1'b1, 5'd10, 32'hAB, 1'b0});
      alu(7, 32'hAB, '0);
      drain();

      // Fill to capacity, reject overflow, wrap
      do_reset();
      for (int i = 1; i <= 15; i++) begin
         do_alloc(1'b1, 5'(i), 1'b0, 1'b0, '0, TAG_W'(i));
         sb.push_back('{TAG_W'(i), 1'b1, 5'(i), 32'h1000 + 32'(i), 1'b0});
      end
      check("full_no_capacity", has_capacity, 0);
      alloc_ena = 1'b1; alloc_has_rd = 1'b1; alloc_rd = 5'd31;
      tick();
      alloc_ena = 1'b0;
      check("full_alloc_ignored", has_capacity, 0);
      check("full_alloc_tag", alloc_tag, 1);
      alu(1, 32'h1001, '0);
      alloc_ena = 1'b1;       // same cycle as the commit: judged on pre-edge count
      tick();
      alloc_ena = 1'b0;
      check("commit_full_alloc_rejected", has_capacity, 1);
      do_alloc(1'b1, 5'd20, 1'b0, 1'b0, '0, 1);
      sb.push_back('{4'd1, 1'b1, 5'd20, 32'h2020, 1'b0});
      check("wrap_full_again", has_capacity, 0);
      check("wrap_next_tag", alloc_tag, 2);
      for (int t = 2; t <= 15; t++) alu(TAG_W'(t), 32'h1000 + 32'(t), '0);
      alu(1, 32'h2020, '0);
      drain();

      // Query bypass and dual-bus capture
      do_reset();
      for (int i = 1; i <= 4; i++) do_alloc(1'b1, 5'(i), 1'b0, 1'b0, '0, TAG_W'(i));
      sb.push_back('{4'd1, 1'b1, 5'd1, 32'hBB, 1'b0});
      sb.push_back('{4'd2, 1'b1, 5'd2, 32'h2222, 1'b0});
      sb.push_back('{4'd3, 1'b1, 5'd3, 32'h11, 1'b0});
      sb.push_back('{4'd4, 1'b1, 5'd4, 32'h22, 1'b0});
      query_tag_a = 3; query_tag_b = 0;
      #1;
      check("query_pending", query_ready_a, 0);
      check("query_tag0_ready", query_ready_b, 1);
      check("query_tag0_data", query_data_b, 0);
      query_tag_b = 9;
      #1;
      check("query_not_busy", query_ready_b, 0);
      in_alu_cdb_rob_tag = 3; in_alu_cdb_data = 32'h11;
      in_ls_cdb_rob_tag  = 4; in_ls_cdb_data  = 32'h22;
      query_tag_b = 4;
      #1;
      check("bypass_a_ready", query_ready_a, 1);
      check("bypass_a_data", query_data_a, 32'h11);
      check("bypass_b_ready", query_ready_b, 1);
      check("bypass_b_data", query_data_b, 32'h22);
      tick();
      idle_cdb();
      #1;
      check("stored_a_data", query_data_a, 32'h11);
      check("stored_b_ready", query_ready_b, 1);
      in_alu_cdb_rob_tag = 1; in_alu_cdb_data = 32'hAA;
      in_ls_cdb_rob_tag  = 1; in_ls_cdb_data  = 32'hBB;
      query_tag_a = 1;
      #1;
      check("same_tag_ls_wins", query_data_a, 32'hBB);
      tick();
      idle_cdb();
      alu(2, 32'h2222, '0);
      drain();

      // Mispredicted branch with link write, younger entries ready behind it
      do_reset();
      do_alloc(1'b1, 5'd1, 1'b0, 1'b1, 32'h104, 1);
      sb.push_back('{4'd1, 1'b1, 5'd1, 32'h108, 1'b0});
      do_alloc(1'b1, 5'd8, 1'b0, 1'b0, '0, 2);
      do_alloc(1'b1, 5'd9, 1'b0, 1'b0, '0, 3);
      in_alu_cdb_rob_tag = 2; in_alu_cdb_data = 32'h1;
      in_ls_cdb_rob_tag  = 3; in_ls_cdb_data  = 32'h2;
      tick();
      idle_cdb();
      alu(1, 32'h108, 32'h200);
      check("flush_before", flush, 0);
      alloc_ena = 1'b1; alloc_has_rd = 1'b1; alloc_rd = 5'd12; alloc_is_branch = 1'b0;
      tick();
      alloc_ena = 1'b0;
      check("flush_pulse", flush, 1);
      check("redirect_pc", redirect_pc, 32'h200);
      check("flush_alloc_tag", alloc_tag, 1);
      check("flush_capacity", has_capacity, 1);
      query_tag_a = 2;
      #1;
      check("flushed_entry_gone", query_ready_a, 0);
      tick();
      check("flush_one_cycle", flush, 0);
      for (int i = 0; i < 4; i++) begin
         check("no_commit_after_flush", commit_rf_ena, 0);
         tick();
      end
      // Correctly predicted branch commits quietly
      do_alloc(1'b1, 5'd3, 1'b0, 1'b1, 32'h300, 1);
      sb.push_back('{4'd1, 1'b1, 5'd3, 32'h304, 1'b0});
      alu(1, 32'h304, 32'h300);
      tick();
      check("good_branch_no_flush", flush, 0);
      drain();

      // Global enable gating
      do_reset();
      ena = 1'b0; alloc_ena = 1'b1; alloc_has_rd = 1'b1; alloc_rd = 5'd2; alloc_is_branch = 1'b0;
      tick();
      alloc_ena = 1'b0; ena = 1'b1;
      do_alloc(1'b1, 5'd2, 1'b0, 1'b0, '0, 1);
      sb.push_back('{4'd1, 1'b1, 5'd2, 32'h77, 1'b0});
      ena = 1'b0;
      alu(1, 32'h55, '0);
      ena = 1'b1;
      query_tag_a = 1;
      #1;
      check("ena_low_no_capture", query_ready_a, 0);
      alu(1, 32'h77, '0);
      ena = 1'b0;
      tick();
      check("ena_low_no_commit", commit_rf_ena, 0);
      ena = 1'b1;
      tick();
      check("ena_high_commit", commit_rf_ena, 1);
      drain();

      // Reset with busy entries and live CDB traffic
      do_reset();
      for (int i = 1; i <= 5; i++) do_alloc(1'b1, 5'(i), 1'b0, 1'b0, '0, TAG_W'(i));
      alu(2, 32'h2, '0);
      rst = 1'b1;
      in_alu_cdb_rob_tag = 1; in_alu_cdb_data = 32'h1;
      tick();
      rst = 1'b0;
      idle_cdb();
      check("midrst_rf_ena", commit_rf_ena, 0);
      check("midrst_commit_tag", commit_tag, 0);
      check("midrst_commit_rd", commit_rd, 0);
      check("midrst_commit_data", commit_data, 0);
      check("midrst_alloc_tag", alloc_tag, 1);
      check("midrst_capacity", has_capacity, 1);
      for (int t = 1; t <= 5; t++) alu(TAG_W'(t), 32'hF0 + 32'(t), '0);
      for (int i = 0; i < 4; i++) begin
         check("midrst_no_commit", commit_rf_ena, 0);
         tick();
      end

      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order buffer of 15 entries that allocates the ROB tags written into reservation-station and load/store entries.
- Snoops both CDBs (ALU and LS) to capture results.
- Retires one completed head entry per cycle: register-file write, store release, or branch check.
- On a branch misprediction, flushes all entries and issues a PC redirect.

Parameters:
ROB_SIZE, 15, number of usable entries; tags run 1..ROB_SIZE, tag 0 means "no producer / ready"
TAG_W, 4, tag width; must satisfy 2^TAG_W > ROB_SIZE
DATA_W, 32, data/PC width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ena  in  1  global enable; when low, state holds and pulse outputs are 0
alloc_ena  in  1  decoder issues an instruction this cycle
alloc_has_rd  in  1  instruction writes rd
alloc_rd  in  5  destination register
alloc_is_store  in  1  instruction is a store
alloc_is_branch  in  1  instruction is a branch/jalr
alloc_pred_next_pc  in  DATA_W  predicted next PC (branches only)
alloc_tag  out  TAG_W  tag the next allocation receives (= tail), combinational
has_capacity  out  1  combinational; count < ROB_SIZE
in_alu_cdb_rob_tag  in  TAG_W  ALU broadcast tag, 0 = idle
in_alu_cdb_data  in  DATA_W  ALU result
in_alu_cdb_next_pc  in  DATA_W  resolved next PC for branches
in_ls_cdb_rob_tag  in  TAG_W  LS broadcast tag, 0 = idle
in_ls_cdb_data  in  DATA_W  load result, or store-address-ready marker
query_tag_a, query_tag_b  in  TAG_W  operand lookup tags
query_ready_a, query_ready_b  out  1  combinational; value available for that tag
query_data_a, query_data_b  out  DATA_W  combinational value
commit_rf_ena  out  1  registered pulse: write register file
commit_rd  out  5  registered
commit_data  out  DATA_W  registered
commit_tag  out  TAG_W  registered; tag retired this cycle
commit_store_ena  out  1  registered pulse: LS buffer may perform store commit_tag
flush  out  1  registered pulse: misprediction
redirect_pc  out  DATA_W  registered; valid when flush=1

Behaviour:
- Entry fields: busy, ready, has_rd, rd, is_store, is_branch, value, pred_next_pc, actual_next_pc.
- Reset:
  - head = tail = 1, count = 0, all busy/ready cleared.
  - All registered outputs are 0.
  - alloc_tag = 1, has_capacity = 1.
- Pointer wrap: increment 1→2→…→ROB_SIZE→1. Tag 0 is never allocated.
- Allocation:
  - Occurs when ena & alloc_ena & has_capacity & !flush_pending.
  - Writes entry[tail] with busy = 1, ready = 0.
  - tail advances and count++ on the next edge.
  - alloc_ena while full is ignored; the decoder must not issue.
- CDB capture (each bus independently):
  - A non-zero tag matching a busy entry sets ready = 1 and value = data.
  - The ALU bus also stores actual_next_pc.
  - Tag 0, or a tag matching a non-busy entry, is ignored.
  - Both buses targeting distinct tags in the same cycle are both captured.
  - The same tag on both buses: LS wins.
- Commit:
  - Occurs when ena & entry[head].busy & entry[head].ready, evaluated on registered state. A result broadcast in cycle N commits at edge N+1 at the earliest.
  - Clears busy, head advances, count-- on that edge.
  - Next-cycle outputs: commit_tag = head, commit_rf_ena = has_rd & (rd != 0), commit_rd, commit_data = value, commit_store_ena = is_store.
  - Pulses last exactly 1 cycle; commit_rd/commit_data are don't-care when commit_rf_ena = 0.
- Simultaneous alloc and commit: count unchanged; capacity is judged on pre-edge count, so a full ROB rejects that alloc.
- Branch check at commit:
  - If is_branch & actual_next_pc != pred_next_pc: flush = 1 and redirect_pc = actual_next_pc next cycle. rd writeback for that entry still happens (jal/jalr link).
  - On the same edge, all entries are cleared, head = tail = 1, count = 0.
  - Any alloc requested in the committing cycle is dropped.
  - CDB traffic arriving while flush = 1 is ignored, since no entries are busy.
- Query ports:
  - Tag 0 → ready = 1, data = 0.
  - Else ready = entry.ready OR a same-cycle CDB match (bypass, LS priority); data accordingly.
  - A non-busy tag returns ready = 0.
- Reset mid-operation: everything returns to reset state on that edge; in-flight CDB data is discarded.
- ena = 0: no alloc, capture, or commit; pulse outputs 0 the following cycle.

Test Plan:
- Reset, then allocate 3 ALU ops (rd = 5, 6, 7): alloc_tag sequence 1, 2, 3. Broadcast tags 2, 1 → commits in order tag 1 then tag 2, each one cycle after the later relevant broadcast, commit_rd = 5 then 6.
- Allocate 15 entries: has_capacity drops after the 15th. A 16th alloc_ena is ignored. Commit tag 1, then allocate again → alloc_tag = 1 (wrap). count stays 15.
- Same cycle: ALU tag 3 data 0x11, LS tag 4 data 0x22, with query_tag_a = 3 and query_tag_b = 4 → query_ready = 1 and data 0x11/0x22 via combinational bypass. Both entries later commit with those values.
- Branch tag 1 with pred_next_pc = 0x104, ALU resolves next_pc = 0x200, and tags 2–3 are allocated behind it → flush = 1, redirect_pc = 0x200. Next cycle alloc_tag = 1, has_capacity = 1, and no commit of tags 2–3.
- Store at tag 1, LS broadcasts tag 1 → commit_store_ena = 1, commit_tag = 1, commit_rf_ena = 0. Also: rd = 0 with has_rd = 1 → commit_rf_ena = 0.
- Assert rst while 5 entries are busy and a CDB is active → next cycle all outputs 0, alloc_tag = 1, and no later commits occur.
